conv_event_dispatcher: RTL
==========================

// Module: conv_event_dispatcher
// PURPOSE
// - Stage between the CONV2D input event FIFO and the convolution compute core.
// - Pops one packed event per transaction and decodes the fields.
// - Bounds-checks the event and serialises its multi-channel spike vector into one
//   (x, y, channel) request per set bit, in ascending channel order.
// - Timestep markers are forwarded as a separate handshake, not expanded as spikes.
// PARAMETERS
// - BITS_PER_COORDINATE  8   width of x and y fields
// - IN_CHANNELS          4   spike vector width = number of input channels
// - IMG_WIDTH            32  x must be < IMG_WIDTH, else event dropped
// - IMG_HEIGHT           32  y must be < IMG_HEIGHT, else event dropped
// - DATA_W  (localparam) 2*BITS_PER_COORDINATE+IN_CHANNELS+1
// - CH_W    (localparam) max(1,$clog2(IN_CHANNELS))
// PORTS
// - clk              in   1       clock, all logic on rising edge
// - rst              in   1       synchronous reset, active-high
// - enable           in   1       0: no new FIFO pops; in-flight event still completes
// - fifo_empty       in   1       input FIFO empty
// - fifo_read_en     out  1       pop strobe, one-cycle pulse
// - fifo_read_data   in   DATA_W  valid the cycle after fifo_read_en
//                                 layout: [DATA_W-1]=ts flag, then x, then y, then spikes[IN_CHANNELS-1:0]
// - evt_valid        out  1       spike request valid
// - evt_ready        in   1       core accepts request
// - evt_x            out  BPC     x coordinate
// - evt_y            out  BPC     y coordinate
// - evt_channel      out  CH_W    input channel index of this spike
// - ts_valid         out  1       timestep marker pending
// - ts_ready         in   1       core accepts timestep marker
// - busy             out  1       FSM not in IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; latched event and spike mask cleared. Reset wins over
//   any handshake in the same cycle; an in-flight event is discarded.
// - FSM states: IDLE, POP, LATCH, DISPATCH, TIMESTEP.
//   - IDLE: enable && !fifo_empty -> assert fifo_read_en for one cycle, go to POP.
//   - POP: wait state; data appears -> LATCH. Exactly one read strobe per event.
//   - LATCH: capture fields.
//     - ts flag=1 -> TIMESTEP; x, y and spike fields are ignored.
//     - else x>=IMG_WIDTH || y>=IMG_HEIGHT || spikes==0 -> IDLE, nothing emitted.
//     - else load mask=spikes -> DISPATCH.
//   - DISPATCH: evt_valid=1; evt_channel = index of lowest set mask bit.
//     - On evt_valid&&evt_ready: clear that bit.
//     - If the cleared bit was the last one -> IDLE, else stay.
//   - TIMESTEP: ts_valid=1; on ts_ready -> IDLE.
// - Handshake rules:
//   - Valid/ready; once valid is asserted, payload stays stable until accepted.
//   - Valid never drops without acceptance.
//   - evt_valid and ts_valid are never high together.
// - Throughput and latency:
//   - Back-to-back accepts: one spike per cycle.
//   - First evt_valid is 3 cycles after fifo_read_en (POP, LATCH, DISPATCH).
//   - Return to IDLE costs one cycle before the next pop.
// - enable deasserted mid-event: current event runs to completion; no further pops.
// - fifo_empty is sampled only in IDLE; fifo_read_en is never asserted while empty.
// - Event order is preserved; timestep markers act as barriers (no spike reordering across them).
// CONFIGURATION
// - CONV_DISPATCH_STATS_EN defined: adds three outputs, each 16-bit, saturating, cleared on rst:
//   - stat_spikes:  incremented per accepted spike request.
//   - stat_dropped: incremented per out-of-bounds event.
//   - stat_ts:      incremented per accepted timestep marker.
// - CONV_DISPATCH_STATS_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING
// - Reset: rst high 2 cycles mid-DISPATCH -> all outputs 0, busy=0, no pop for 1 cycle after release.
// - Multi-spike: event x=5,y=7,spikes=4'b1011, evt_ready=1 -> channels 0,1,3 on consecutive cycles, then IDLE.
// - Backpressure: spikes=4'b0110, evt_ready low 4 cycles -> evt_channel=1 held stable; after ready, ch1 then ch2.
// - Timestep: word with ts flag=1, spikes=4'b1111 -> ts_valid only, no evt_valid; ts_ready delayed 3 cycles, held.
// - Drop: x=32 (IMG_WIDTH=32) or spikes=0 -> no output handshake; with STATS_EN, stat_dropped +1 for x=32 case only.
// - Flow: enable=0 with fifo_empty=0 -> fifo_read_en stays 0; fifo_empty=1 in IDLE -> no pops; 3 queued events drained in order.

Source files
------------

// File: rtl/conv_event_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_event_dispatcher_if
// Description : Bundles the FIFO pop, spike-request and timestep handshakes of
//               conv_event_dispatcher. Stats ports exist only when
//               CONV_DISPATCH_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_event_dispatcher_if #(
   parameter int BITS_PER_COORDINATE = 8,
   parameter int IN_CHANNELS         = 4
);
   localparam int DATA_W = 2*BITS_PER_COORDINATE + IN_CHANNELS + 1;
   localparam int CH_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

   logic                           enable;
   logic                           fifo_empty;
   logic                           fifo_read_en;
   logic [DATA_W-1:0]              fifo_read_data;
   logic                           evt_valid;
   logic                           evt_ready;
   logic [BITS_PER_COORDINATE-1:0] evt_x;
   logic [BITS_PER_COORDINATE-1:0] evt_y;
   logic [CH_W-1:0]                evt_channel;
   logic                           ts_valid;
   logic                           ts_ready;
   logic                           busy;
`ifdef CONV_DISPATCH_STATS_EN
   logic [15:0]                    stat_spikes;
   logic [15:0]                    stat_dropped;
   logic [15:0]                    stat_ts;
`endif

   // Dispatcher side
   modport master (
`ifdef CONV_DISPATCH_STATS_EN
      output stat_spikes, output stat_dropped, output stat_ts,
`endif
      input  enable, input fifo_empty, input fifo_read_data,
      input  evt_ready, input ts_ready,
      output fifo_read_en, output evt_valid, output evt_x, output evt_y,
      output evt_channel, output ts_valid, output busy
   );

   // FIFO / compute-core side
   modport slave (
`ifdef CONV_DISPATCH_STATS_EN
      input  stat_spikes, input stat_dropped, input stat_ts,
`endif
      output enable, output fifo_empty, output fifo_read_data,
      output evt_ready, output ts_ready,
      input  fifo_read_en, input evt_valid, input evt_x, input evt_y,
      input  evt_channel, input ts_valid, input busy
   );
endinterface
`default_nettype wire

// File: rtl/conv_event_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : conv_event_dispatcher
// Description : Pops packed CONV2D events, bounds-checks them and serialises the
//               spike vector into per-channel requests; forwards timestep
//               markers. Optional counters under CONV_DISPATCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_event_dispatcher #(
   parameter int BITS_PER_COORDINATE = 8,
   parameter int IN_CHANNELS         = 4,
   parameter int IMG_WIDTH           = 32,
   parameter int IMG_HEIGHT          = 32
) (
   input wire logic               clk,
   input wire logic               rst,
   conv_event_dispatcher_if.master bus
);
   localparam int DATA_W = 2*BITS_PER_COORDINATE + IN_CHANNELS + 1;
   localparam int CH_W   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POP      = 3'd1,
      S_LATCH    = 3'd2,
      S_DISPATCH = 3'd3,
      S_TIMESTEP = 3'd4
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [DATA_W-1:0]              r_word;
   logic [IN_CHANNELS-1:0]         r_mask;
   logic                           r_hold;

   logic                           w_ts;
   logic [BITS_PER_COORDINATE-1:0] w_x;
   logic [BITS_PER_COORDINATE-1:0] w_y;
   logic [IN_CHANNELS-1:0]         w_spikes;
   logic                           w_oob;
   logic [IN_CHANNELS-1:0]         w_lowbit;
   logic [IN_CHANNELS-1:0]         w_mask_rest;
   logic [CH_W-1:0]                w_ch;
   logic                           w_found;
   logic                           w_rd_en;
   logic                           w_evt_valid;
   logic                           w_ts_valid;

   assign w_ts     = r_word[DATA_W-1];
   assign w_x      = r_word[DATA_W-2 -: BITS_PER_COORDINATE];
   assign w_y      = r_word[IN_CHANNELS +: BITS_PER_COORDINATE];
   assign w_spikes = r_word[IN_CHANNELS-1:0];
   assign w_oob    = (int'(w_x) >= IMG_WIDTH) || (int'(w_y) >= IMG_HEIGHT);

   // Two's-complement trick isolates the lowest pending channel
   assign w_lowbit    = r_mask & (~r_mask + 1'b1);
   assign w_mask_rest = r_mask & ~w_lowbit;

   always_comb begin
      w_ch    = '0;
      w_found = 1'b0;
      for (int i = 0; i < IN_CHANNELS; i++) begin
         if (r_mask[i] && !w_found) begin
            w_ch    = CH_W'(i);
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_rd_en     = 1'b0;
      w_evt_valid = 1'b0;
      w_ts_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable && !bus.fifo_empty && !r_hold) begin
               w_rd_en = 1'b1;
               w_next  = S_POP;
            end
         end
         S_POP: begin
            w_next = S_LATCH;
         end
         S_LATCH: begin
            if (w_ts) begin
               w_next = S_TIMESTEP;
            end else if (w_oob || (w_spikes == '0)) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            w_evt_valid = 1'b1;
            if (bus.evt_ready && (w_mask_rest == '0)) begin
               w_next = S_IDLE;
            end
         end
         S_TIMESTEP: begin
            w_ts_valid = 1'b1;
            if (bus.ts_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // r_hold blocks the first pop after reset release
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
         r_mask <= '0;
         r_hold <= 1'b1;
      end else begin
         r_hold <= 1'b0;
         if (r_state == S_POP) begin
            r_word <= bus.fifo_read_data;
         end
         if ((r_state == S_LATCH) && (w_next == S_DISPATCH)) begin
            r_mask <= w_spikes;
         end else if ((r_state == S_DISPATCH) && bus.evt_ready) begin
            r_mask <= w_mask_rest;
         end
      end
   end

   assign bus.fifo_read_en = w_rd_en & ~rst;
   assign bus.evt_valid    = w_evt_valid & ~rst;
   assign bus.ts_valid     = w_ts_valid & ~rst;
   assign bus.busy         = (r_state != S_IDLE) & ~rst;
   assign bus.evt_x        = w_x;
   assign bus.evt_y        = w_y;
   assign bus.evt_channel  = w_ch;

`ifdef CONV_DISPATCH_STATS_EN
   logic [15:0] r_stat_spikes;
   logic [15:0] r_stat_dropped;
   logic [15:0] r_stat_ts;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_spikes  <= '0;
         r_stat_dropped <= '0;
         r_stat_ts      <= '0;
      end else begin
         if ((r_state == S_DISPATCH) && bus.evt_ready && (r_stat_spikes != 16'hFFFF)) begin
            r_stat_spikes <= r_stat_spikes + 16'd1;
         end
         if ((r_state == S_LATCH) && !w_ts && w_oob && (r_stat_dropped != 16'hFFFF)) begin
            r_stat_dropped <= r_stat_dropped + 16'd1;
         end
         if ((r_state == S_TIMESTEP) && bus.ts_ready && (r_stat_ts != 16'hFFFF)) begin
            r_stat_ts <= r_stat_ts + 16'd1;
         end
      end
   end

   assign bus.stat_spikes  = r_stat_spikes;
   assign bus.stat_dropped = r_stat_dropped;
   assign bus.stat_ts      = r_stat_ts;
`endif

endmodule
`default_nettype wire
